// File: rtl/lsu_dbus_ctrl_pkg.sv
// Shared definitions for the load/store unit: data-bus payloads, FSM states and funct3 codes.
package lsu_dbus_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [1:0] type_lsu_states_e;
  localparam logic [1:0] LSU_IDLE  = 2'd0;
  localparam logic [1:0] LSU_LOAD  = 2'd1;
  localparam logic [1:0] LSU_STORE = 2'd2;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef struct packed {
    logic            req;
    logic            w_en;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] w_data;
    logic [3:0]      sel_byte;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [XLEN-1:0] r_data;
    logic            ack;
  } type_peri2dbus_s;

  // Stores have no unsigned variants, so their legal set is smaller than the load set.
  function automatic logic lsu_f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {LSU_SB, LSU_SH, LSU_SW};
    return f3 inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: lane enables, store replication, load extraction/extension.
// LSU_MISALIGN_TRAP_EN selects trapping (flag raised) versus silent force-alignment.
module lsu_align
  import lsu_dbus_ctrl_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] addr_aligned,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext,
  output logic [3:0]      sel_byte,
  output logic            misalign
);

  logic [15:0] lane;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    addr_aligned = addr;
    misalign     = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end
`else
  always_comb begin
    misalign     = 1'b0;
    addr_aligned = addr;
    if (funct3[1:0] == 2'b01)      addr_aligned[0]   = 1'b0;
    else if (funct3[1:0] == 2'b10) addr_aligned[1:0] = 2'b00;
  end
`endif

  assign lane = 16'(rdata >> {addr_aligned[1:0], 3'b000});

  always_comb begin
    sel_byte  = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (funct3[1:0])
      2'b00: begin
        sel_byte  = 4'b0001 << addr_aligned[1:0];
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = funct3[2] ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      2'b01: begin
        sel_byte  = 4'b0011 << {addr_aligned[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = funct3[2] ? {16'h0, lane} : {{16{lane[15]}}, lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_dbus_ctrl.sv
// Load/store unit between execute and the data bus; one access in flight at a time.
// Build option LSU_MISALIGN_TRAP_EN (see lsu_align) traps misaligned half/word accesses.
module lsu_dbus_ctrl
  import lsu_dbus_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] DMEM_BASE   = 32'h0000_0000,
  parameter logic [XLEN-1:0] DMEM_MASK   = 32'hFFC0_0000,
  parameter int unsigned     ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_req_i,
  output logic            lsu_ready_o,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_done_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_err_o,
  output logic            lsu_misalign_o,
  output type_dbus2peri_s lsu2dbus_o,
  output logic            dmem_sel_o,
  input  logic            store_busy_i,
  input  type_peri2dbus_s dbus2lsu_i
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [XLEN-1:0]  addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d, done_q, done_d, err_q, err_d, mis_q, mis_d;
  logic             idle, timeout, dmem_sel, store_done;
  logic [2:0]       al_f3;
  logic [XLEN-1:0]  al_addr, al_wdata, al_addr_aligned, al_wdata_rep, al_rdata_ext;
  logic [3:0]       al_sel;
  logic             al_misalign;

  assign idle       = (state_q == LSU_IDLE);
  assign timeout    = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign dmem_sel   = ((addr_q & DMEM_MASK) == DMEM_BASE);
  assign store_done = dmem_sel ? (seen_q && !store_busy_i) : dbus2lsu_i.ack;

  // While idle the aligner looks at the incoming request so traps and alignment resolve at accept.
  assign al_f3    = idle ? lsu_funct3_i : f3_q;
  assign al_addr  = idle ? lsu_addr_i   : addr_q;
  assign al_wdata = idle ? lsu_wdata_i  : wdata_q;

  lsu_align u_align (
    .funct3       (al_f3),
    .addr         (al_addr),
    .wdata        (al_wdata),
    .rdata        (dbus2lsu_i.r_data),
    .addr_aligned (al_addr_aligned),
    .wdata_rep    (al_wdata_rep),
    .rdata_ext    (al_rdata_ext),
    .sel_byte     (al_sel),
    .misalign     (al_misalign)
  );

  // Next-state and completion logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (lsu_req_i) begin
          we_d    = lsu_we_i;
          f3_d    = lsu_funct3_i;
          addr_d  = al_addr_aligned;
          wdata_d = lsu_wdata_i;
          cnt_d   = '0;
          seen_d  = 1'b0;
          if (!lsu_f3_legal(lsu_we_i, lsu_funct3_i)) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (al_misalign) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            mis_d  = 1'b1;
          end else begin
            state_d = lsu_we_i ? LSU_STORE : LSU_LOAD;
          end
        end
      end
      LSU_LOAD: begin
        if (dbus2lsu_i.ack) begin
          done_d  = 1'b1;
          rdata_d = al_rdata_ext;
          state_d = LSU_IDLE;
        end else if (timeout) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = LSU_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_STORE: begin
        if (store_busy_i) seen_d = 1'b1;
        if (store_done) begin
          done_d  = 1'b1;
          state_d = LSU_IDLE;
        end else if (timeout) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = LSU_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign lsu_ready_o    = idle && !rst;
  assign lsu_done_o     = done_q;
  assign lsu_err_o      = err_q;
  assign lsu_misalign_o = mis_q;
  assign lsu_rdata_o    = rdata_q;
  assign dmem_sel_o     = dmem_sel;

  always_comb begin
    lsu2dbus_o          = '0;
    lsu2dbus_o.req      = !idle;
    lsu2dbus_o.w_en     = we_q;
    lsu2dbus_o.addr     = addr_q;
    lsu2dbus_o.w_data   = al_wdata_rep;
    lsu2dbus_o.sel_byte = al_sel;
  end

endmodule
